// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART-driven Wishbone master: FSM states and
// the command/response byte codes of the serial protocol.
package uart_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_WB_CYC,
        ST_SEND,
        ST_TX_HOLD
    } state_t;

    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

endpackage

// File: rtl/uart_wb_master_cycle_timer.sv
// Saturating up-counter that flags when LIMIT enabled cycles have elapsed
// since the last clear. It never wraps, so a stuck condition stays expired.
module cycle_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] MAX = CW'(LIMIT);

    logic [CW-1:0] cnt;

    // Count enabled cycles, holding at MAX once reached
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == MAX);

endmodule

// File: rtl/uart_wb_master.sv
// Decodes 'W' addr data / 'R' addr frames from the UART receiver, runs one
// classic Wishbone single cycle per frame and returns one response byte.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int AW            = 8,
    parameter int WB_TIMEOUT    = 1024,
    parameter int FRAME_TIMEOUT = 120000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_word,
    input  logic          rx_rxne,
    input  logic          rx_ore,
    output logic          rx_rxne_clear,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_busy,
    output logic [AW-1:0] wb_adr_o,
    output logic [7:0]    wb_dat_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [7:0]    wb_dat_i,
    input  logic          wb_ack_i,
    output logic          busy
);

    state_t state;
    logic   we_q;
    logic   clr_d;
    logic   in_frame;
    logic   in_rx_state;
    logic   rx_ok;
    logic   frame_abort;
    logic   byte_take;
    logic   last_byte;
    logic   frame_expired;
    logic   wb_expired;

    assign in_frame    = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign in_rx_state = (state == ST_IDLE) || in_frame;
    // The UART still shows the consumed byte while it reacts to the clear
    // pulse, so the pulse cycle and the one after it are not trusted.
    assign rx_ok       = rx_rxne && !rx_rxne_clear && !clr_d;
    assign frame_abort = in_frame && (rx_ore || frame_expired);
    assign byte_take   = in_rx_state && rx_ok && !frame_abort;
    assign last_byte   = byte_take &&
                         (((state == ST_GET_ADDR) && !we_q) || (state == ST_GET_DATA));

    // Inter-byte gap limit: restarts on each accepted byte, runs mid-frame
    cycle_timer #(.LIMIT(FRAME_TIMEOUT)) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (byte_take || (state == ST_IDLE)),
        .en      (in_frame),
        .expired (frame_expired)
    );

    // Bus-cycle limit: also counts the launch cycle so that cyc/stb stay
    // high for exactly WB_TIMEOUT cycles before the error response
    cycle_timer #(.LIMIT(WB_TIMEOUT)) u_wb_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_IDLE),
        .en      ((state == ST_WB_CYC) || last_byte),
        .expired (wb_expired)
    );

    // Frame decode, bus cycle and response sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            we_q          <= 1'b0;
            clr_d         <= 1'b0;
            rx_rxne_clear <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            wb_we_o       <= 1'b0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_rxne_clear <= byte_take;
            clr_d         <= rx_rxne_clear;
            tx_valid      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (byte_take && ((rx_word == CMD_WR) || (rx_word == CMD_RD))) begin
                        we_q  <= (rx_word == CMD_WR);
                        state <= ST_GET_ADDR;
                        busy  <= 1'b1;
                    end
                end
                ST_GET_ADDR: begin
                    if (frame_abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (byte_take) begin
                        wb_adr_o <= AW'(rx_word);
                        if (we_q) begin
                            state <= ST_GET_DATA;
                        end else begin
                            state    <= ST_WB_CYC;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (frame_abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (byte_take) begin
                        wb_dat_o <= rx_word;
                        state    <= ST_WB_CYC;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                    end
                end
                ST_WB_CYC: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        tx_data  <= we_q ? RSP_OK : wb_dat_i;
                        state    <= ST_SEND;
                    end else if (wb_expired) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        tx_data  <= RSP_ERR;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_valid <= 1'b1;
                        state    <= ST_TX_HOLD;
                    end
                end
                ST_TX_HOLD: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: a UART byte feeder, a memory-backed Wishbone
// slave with programmable ack latency (0x20..0x2F never acks), a transmitter
// busy model and a frame-level reference model compared every cycle.
module tb_uart_wb_master;

    localparam int WB_TO = 16;
    localparam int FR_TO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_word = 8'h00;
    logic       rx_rxne = 1'b0;
    logic       rx_ore = 1'b0;
    logic       rx_rxne_clear;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy = 1'b0;
    logic [7:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic       wb_we_o, wb_cyc_o, wb_stb_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;
    logic       busy;

    uart_wb_master #(.AW(8), .WB_TIMEOUT(WB_TO), .FRAME_TIMEOUT(FR_TO)) dut (
        .clk(clk), .rst(rst), .rx_word(rx_word), .rx_rxne(rx_rxne), .rx_ore(rx_ore),
        .rx_rxne_clear(rx_rxne_clear), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_busy(tx_busy), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
        logic       err;
    } bus_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_q[$];
    logic [7:0] ref_mem[256];

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic void fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event did not match model", name);
    endfunction

    function automatic logic unmapped(input logic [7:0] a);
        return a[7:4] == 4'h2;
    endfunction

    // ---------------- Wishbone slave ----------------
    int         slv_lat = 0;
    int         wait_cnt = 0;
    logic       booted = 1'b0;
    logic [7:0] slv_mem[256];
    logic [255:0] slv_wr;

    always_comb begin
        wb_ack_i = wb_cyc_o && wb_stb_o && !unmapped(wb_adr_o) && (wait_cnt >= slv_lat);
        wb_dat_i = slv_wr[wb_adr_o] ? slv_mem[wb_adr_o] : (wb_adr_o ^ 8'h2C);
    end

    always @(posedge clk) begin
        if (!booted) slv_wr <= '0;
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (wb_ack_i && wb_we_o) begin
            slv_mem[wb_adr_o] <= wb_dat_o;
            slv_wr[wb_adr_o]  <= 1'b1;
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    int         cyc_n = 0;
    int         cyc_len = 0, last_cyc_len = 0, cyc_count = 0, tx_count = 0;
    int         exp_tx_cyc = -1, last_ack_cyc = 0, last_tx_cyc = 0;
    bit         rst_prev = 0, prev_cyc = 0, drop_due = 0, acked = 0, pending = 0;
    bit         prev_clr = 0, rxne_prev = 0, cur_err = 0, cur_we = 0;
    logic [7:0] start_adr = 8'h00, last_adr = 8'h00, last_dat = 8'h00, last_tx = 8'h00;
    logic       last_we = 1'b0;

    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (rst) begin
                rst_prev = 1;
            end else if (rst_prev) begin
                rst_prev = 0;
                chk("rst_cyc", int'(wb_cyc_o), 0);
                chk("rst_stb", int'(wb_stb_o), 0);
                chk("rst_we", int'(wb_we_o), 0);
                chk("rst_txv", int'(tx_valid), 0);
                chk("rst_clr", int'(rx_rxne_clear), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_adr", int'(wb_adr_o), 0);
                chk("rst_dat", int'(wb_dat_o), 0);
                chk("rst_txd", int'(tx_data), 0);
                exp_tx.delete();
                exp_bus.delete();
                pending = 0; exp_tx_cyc = -1; prev_cyc = 0; drop_due = 0;
                prev_clr = 0; rxne_prev = rx_rxne;
            end else begin
                if (drop_due) begin
                    chk("cyc_drop_after_ack", int'(wb_cyc_o), 0);
                    drop_due = 0;
                end
                chk("stb_tracks_cyc", int'(wb_stb_o), int'(wb_cyc_o));
                if (wb_cyc_o) begin
                    if (!prev_cyc) begin
                        cyc_len = 0; acked = 0; cyc_count++;
                        start_adr = wb_adr_o; last_adr = wb_adr_o;
                        last_dat = wb_dat_o; last_we = wb_we_o;
                        if (exp_bus.size() == 0) begin
                            fail("unexpected_bus_cycle");
                            cur_err = 0; cur_we = wb_we_o;
                        end else begin
                            e = exp_bus.pop_front();
                            cur_err = e.err; cur_we = e.we;
                            chk("bus_adr", int'(wb_adr_o), int'(e.adr));
                            chk("bus_we", int'(wb_we_o), int'(e.we));
                            if (e.we) chk("bus_dat", int'(wb_dat_o), int'(e.dat));
                        end
                    end
                    chk("adr_stable", int'(wb_adr_o), int'(start_adr));
                    chk("we_stable", int'(wb_we_o), int'(cur_we));
                    chk("busy_in_cycle", int'(busy), 1);
                    cyc_len++;
                    if (wb_ack_i) begin
                        acked = 1; drop_due = 1; last_ack_cyc = cyc_n;
                    end
                end else if (prev_cyc) begin
                    chk("ack_vs_map", int'(acked), int'(!cur_err));
                    if (!acked) chk("timeout_len", cyc_len, WB_TO);
                    last_cyc_len = cyc_len;
                    pending = 1; exp_tx_cyc = -1;
                end
                prev_cyc = wb_cyc_o;

                if (tx_valid) begin
                    if (!pending || exp_tx_cyc < 0) fail("unexpected_tx_valid");
                    else chk("tx_cycle", cyc_n, exp_tx_cyc);
                    if (exp_tx.size() == 0) fail("tx_without_frame");
                    else chk("tx_data", int'(tx_data), int'(exp_tx.pop_front()));
                    pending = 0; exp_tx_cyc = -1;
                    last_tx = tx_data; last_tx_cyc = cyc_n; tx_count++;
                end else if (pending && exp_tx_cyc >= 0 && cyc_n > exp_tx_cyc) begin
                    fail("tx_late");
                    pending = 0; exp_tx_cyc = -1;
                end
                if (pending && exp_tx_cyc < 0 && !tx_busy) exp_tx_cyc = cyc_n + 1;

                if (rx_rxne_clear) begin
                    chk("clr_needs_rxne", int'(rxne_prev), 1);
                    chk("clr_single", int'(prev_clr), 0);
                end
                prev_clr = rx_rxne_clear;
                rxne_prev = rx_rxne;
            end
        end
    end

    // ---------------- Stimulus ----------------
    int gap = 0, gap_left = 0, busy_len = 2, busy_left = 0;
    bit hold_busy = 0;

    task automatic tick();
        bit clr_seen, txv_seen;
        @(negedge clk);
        clr_seen = rx_rxne_clear;
        txv_seen = tx_valid;
        @(posedge clk);
        #1;
        if (clr_seen) rx_rxne = 1'b0;
        if (txv_seen) busy_left = busy_len;
        else if (busy_left > 0) busy_left--;
        tx_busy = hold_busy || (busy_left > 0);
        if (!rx_rxne && rx_q.size() > 0) begin
            if (gap_left > 0) gap_left--;
            else begin
                rx_word = rx_q.pop_front();
                rx_rxne = 1'b1;
                gap_left = gap;
            end
        end
    endtask

    task automatic queue_frame(input logic [7:0] cmd, input logic [7:0] adr, input logic [7:0] dat);
        bus_t e;
        rx_q.push_back(cmd);
        if (cmd == 8'h57 || cmd == 8'h52) begin
            rx_q.push_back(adr);
            e.we = (cmd == 8'h57); e.adr = adr; e.dat = dat; e.err = unmapped(adr);
            if (e.we) rx_q.push_back(dat);
            exp_bus.push_back(e);
            if (e.err) exp_tx.push_back(8'h45);
            else if (e.we) begin
                ref_mem[adr] = dat;
                exp_tx.push_back(8'h4B);
            end else exp_tx.push_back(ref_mem[adr]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (n < 3000 && !(rx_q.size() == 0 && !rx_rxne && exp_bus.size() == 0 &&
                             exp_tx.size() == 0 && !wb_cyc_o && !busy)) begin
            tick();
            n++;
        end
        if (n >= 3000) fail(tag);
        tick();
        tick();
    endtask

    initial begin
        int c0, t0, n, busy_fall;
        logic [7:0] b, a, d;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h2C;
        repeat (3) tick();
        rst = 1'b0;
        booted = 1'b1;
        tick();

        // Read 0x10: slave returns 0x3C, response two cycles after ack
        queue_frame(8'h52, 8'h10, 8'h00);
        wait_idle("idle_rd1");
        chk("rd1_adr", int'(last_adr), 'h10);
        chk("rd1_we", int'(last_we), 0);
        chk("rd1_tx", int'(last_tx), 'h3C);
        chk("rd1_ack_to_tx", last_tx_cyc - last_ack_cyc, 2);

        // Write 0xA5 to 0x10
        queue_frame(8'h57, 8'h10, 8'hA5);
        wait_idle("idle_wr1");
        chk("wr1_adr", int'(last_adr), 'h10);
        chk("wr1_dat", int'(last_dat), 'hA5);
        chk("wr1_we", int'(last_we), 1);
        chk("wr1_tx", int'(last_tx), 'h4B);

        // Unmapped read: full timeout then 'E'
        queue_frame(8'h52, 8'h20, 8'h00);
        wait_idle("idle_to");
        chk("to_len", last_cyc_len, 16);
        chk("to_tx", int'(last_tx), 'h45);

        // Truncated write frame: dropped by the frame timer
        c0 = cyc_count; t0 = tx_count;
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h10);
        repeat (FR_TO + 10) tick();
        chk("ft_busy", int'(busy), 0);
        chk("ft_no_cycle", cyc_count, c0);
        chk("ft_no_tx", tx_count, t0);
        queue_frame(8'h52, 8'h10, 8'h00);
        wait_idle("idle_ft");
        chk("ft_rd_tx", int'(last_tx), 'hA5);

        // Junk byte is dropped, then one read
        c0 = cyc_count;
        queue_frame(8'h33, 8'h00, 8'h00);
        queue_frame(8'h52, 8'h10, 8'h00);
        wait_idle("idle_junk");
        chk("junk_one_cycle", cyc_count, c0 + 1);
        chk("junk_rd_tx", int'(last_tx), 'hA5);

        // Transmitter busy for 500 cycles across the read ack
        c0 = cyc_count;
        hold_busy = 1;
        tick();
        queue_frame(8'h52, 8'h10, 8'h00);
        n = 0;
        while (n < 500 && !(cyc_count > c0 && !wb_cyc_o)) begin tick(); n++; end
        if (n >= 500) fail("hold_no_cycle");
        repeat (500) tick();
        hold_busy = 0;
        tick();
        busy_fall = cyc_n + 1;
        wait_idle("idle_hold");
        chk("hold_tx_after_fall", last_tx_cyc, busy_fall + 1);
        chk("hold_tx", int'(last_tx), 'hA5);

        // Overrun mid-frame aborts without response
        c0 = cyc_count; t0 = tx_count;
        rx_q.push_back(8'h52);
        n = 0;
        while (n < 100 && !busy) begin tick(); n++; end
        chk("ore_entered_frame", int'(busy), 1);
        tick();
        rx_ore = 1'b1;
        tick();
        rx_ore = 1'b0;
        tick();
        tick();
        chk("ore_busy", int'(busy), 0);
        repeat (20) tick();
        chk("ore_no_cycle", cyc_count, c0);
        chk("ore_no_tx", tx_count, t0);

        // Reset in the middle of a bus cycle
        t0 = tx_count;
        queue_frame(8'h52, 8'h21, 8'h00);
        n = 0;
        while (n < 100 && !wb_cyc_o) begin tick(); n++; end
        if (n >= 100) fail("rst_no_cycle");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_cyc", int'(wb_cyc_o), 0);
        repeat (40) tick();
        chk("rst_mid_no_tx", tx_count, t0);

        // Randomized frames
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(0, 7);
            a = 8'($urandom);
            d = 8'($urandom);
            slv_lat = $urandom_range(0, 3);
            gap = $urandom_range(0, 4);
            busy_len = $urandom_range(1, 6);
            if (n <= 2) queue_frame(8'h57, a, d);
            else if (n <= 5) queue_frame(8'h52, a, d);
            else if (n == 6) begin
                b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                queue_frame(b, 8'h00, 8'h00);
            end else queue_frame(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52,
                                 8'h20 | 8'($urandom_range(0, 15)), d);
            wait_idle("idle_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
